// File: rtl/frame_packer_pkg.sv
// Shared types and helpers for the ping-pong frame packer.
// Payload words and the preamble are limited to MAX_W bits.
package frame_packer_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {StStart, StPre, StPay} rd_state_e;

    // Counter width that stays legal when the terminal count is 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned frame_beats(input int unsigned pre_bits,
                                                input int unsigned payload_words,
                                                input int unsigned in_w,
                                                input int unsigned out_w);
        return (pre_bits + payload_words * in_w) / out_w;
    endfunction

    function automatic int unsigned beats_per_word(input int unsigned in_w,
                                                   input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned pre_beats(input int unsigned pre_bits,
                                              input int unsigned out_w);
        return pre_bits / out_w;
    endfunction

    // Beat k of a w-bit word, right-aligned; the caller keeps the low out_w bits.
    function automatic logic [MAX_W-1:0] beat_sel(input logic [MAX_W-1:0] word,
                                                  input int unsigned k,
                                                  input int unsigned w,
                                                  input int unsigned out_w,
                                                  input logic msb_first);
        if (msb_first) begin
            return word >> (w - out_w * (k + 1));
        end
        return word >> (out_w * k);
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank simple dual-port RAM; address MSB selects the bank, 1-cycle read.
module frame_bank_ram #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 2
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IDX_W:0]   i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    localparam int unsigned AW = $clog2(2 * WORDS);

    logic [WIDTH-1:0] mem [2*WORDS];
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;

    // Bank 1 starts at WORDS so exactly 2*WORDS entries are stored.
    assign wa = i_waddr[IDX_W] ? AW'(WORDS) + AW'(i_waddr[IDX_W-1:0]) : AW'(i_waddr[IDX_W-1:0]);
    assign ra = i_raddr[IDX_W] ? AW'(WORDS) + AW'(i_raddr[IDX_W-1:0]) : AW'(i_raddr[IDX_W-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[wa] <= i_wdata;
        end
        o_rdata <= mem[ra];
    end

endmodule

// File: rtl/frame_packer.sv
// Packs input words into ping-pong banks and emits a continuous stream of
// fixed-length preamble + payload frames, with idle frames when no bank is ready.
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int unsigned              PAYLOAD_WORDS = 243,
    parameter int unsigned              IN_W          = 8,
    parameter int unsigned              OUT_W         = 1,
    parameter int unsigned              PREAMBLE_BITS = 32,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 32'h1ACFFC1D,
    parameter logic [IN_W-1:0]          IDLE_WORD     = '0,
    parameter logic [IN_W-1:0]          PAD_WORD      = '0,
    parameter bit                       MSB_FIRST     = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_idle
);
    localparam int unsigned BPW   = beats_per_word(IN_W, OUT_W);
    localparam int unsigned PRE_N = pre_beats(PREAMBLE_BITS, OUT_W);
    localparam int unsigned IDX_W = cnt_width(PAYLOAD_WORDS);
    localparam int unsigned LEN_W = $clog2(PAYLOAD_WORDS + 1);
    localparam int unsigned PRE_W = cnt_width(PRE_N);
    localparam int unsigned SUB_W = cnt_width(BPW);

    logic [1:0]       full_q, full_d;
    logic [LEN_W-1:0] len_q [2];
    logic             wr_sel_q;
    logic [IDX_W-1:0] wr_cnt_q;
    logic             accept, wr_done;

    rd_state_e        st_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [IDX_W-1:0] word_cnt_q, nxt_word;
    logic [SUB_W-1:0] sub_cnt_q;
    logic             rd_sel_q, rd_sel_d;
    logic             ld, rd_done;
    logic [IN_W-1:0]  rdata, pay_word;

    assign o_ready = !full_q[wr_sel_q];
    assign accept  = i_valid && o_ready;
    assign wr_done = accept && (i_last || wr_cnt_q == IDX_W'(PAYLOAD_WORDS - 1));

    // The output register reloads whenever the current beat is consumed or empty.
    assign ld       = !o_valid || i_ready;
    assign rd_done  = o_valid && i_ready && o_eof && !o_idle;
    assign rd_sel_d = rd_done ? !rd_sel_q : rd_sel_q;

    always_comb begin
        full_d = full_q;
        if (rd_done) full_d[rd_sel_q] = 1'b0;
        if (wr_done) full_d[wr_sel_q] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            full_q   <= '0;
            len_q    <= '{default: '0};
            wr_sel_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            if (wr_done) begin
                len_q[wr_sel_q] <= LEN_W'(wr_cnt_q) + 1'b1;
                wr_cnt_q        <= '0;
                wr_sel_q        <= !wr_sel_q;
            end else if (accept) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    // Address the word the reader will need after this edge, hiding RAM latency.
    always_comb begin
        nxt_word = word_cnt_q;
        if (ld) begin
            if (st_q != StPay) begin
                nxt_word = '0;
            end else if (sub_cnt_q == SUB_W'(BPW - 1)) begin
                nxt_word = (word_cnt_q == IDX_W'(PAYLOAD_WORDS - 1)) ? '0 : word_cnt_q + 1'b1;
            end
        end
    end

    frame_bank_ram #(
        .WORDS(PAYLOAD_WORDS),
        .WIDTH(IN_W),
        .IDX_W(IDX_W)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (accept),
        .i_waddr({wr_sel_q, wr_cnt_q}),
        .i_wdata(i_data),
        .i_raddr({rd_sel_d, nxt_word}),
        .o_rdata(rdata)
    );

    assign pay_word = o_idle ? IDLE_WORD :
                      (LEN_W'(word_cnt_q) < len_q[rd_sel_q]) ? rdata : PAD_WORD;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            st_q       <= StStart;
            pre_cnt_q  <= '0;
            word_cnt_q <= '0;
            sub_cnt_q  <= '0;
            rd_sel_q   <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_idle     <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
            if (ld) begin
                o_valid <= 1'b1;
                o_sof   <= 1'b0;
                o_eof   <= 1'b0;
                unique case (st_q)
                    StStart: begin
                        // A bank completing this very edge is not yet in full_q.
                        o_sof      <= 1'b1;
                        o_idle     <= !full_q[rd_sel_d];
                        o_data     <= OUT_W'(beat_sel(MAX_W'(PREAMBLE), 0, PREAMBLE_BITS,
                                                      OUT_W, 1'b1));
                        word_cnt_q <= '0;
                        sub_cnt_q  <= '0;
                        if (PRE_N == 1) begin
                            st_q <= StPay;
                        end else begin
                            st_q      <= StPre;
                            pre_cnt_q <= PRE_W'(1);
                        end
                    end
                    StPre: begin
                        o_data <= OUT_W'(beat_sel(MAX_W'(PREAMBLE), 32'(pre_cnt_q),
                                                  PREAMBLE_BITS, OUT_W, 1'b1));
                        if (pre_cnt_q == PRE_W'(PRE_N - 1)) begin
                            st_q <= StPay;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                        end
                    end
                    StPay: begin
                        o_data <= OUT_W'(beat_sel(MAX_W'(pay_word), 32'(sub_cnt_q), IN_W,
                                                  OUT_W, MSB_FIRST));
                        if (sub_cnt_q == SUB_W'(BPW - 1)) begin
                            sub_cnt_q <= '0;
                            if (word_cnt_q == IDX_W'(PAYLOAD_WORDS - 1)) begin
                                o_eof      <= 1'b1;
                                word_cnt_q <= '0;
                                st_q       <= StStart;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                            end
                        end else begin
                            sub_cnt_q <= sub_cnt_q + 1'b1;
                        end
                    end
                    default: st_q <= StStart;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench: a frame-level model predicts every output beat and o_ready.
module tb_frame_packer;

    localparam int unsigned PW  = 4;
    localparam logic [7:0]  PRE = 8'hA5;
    localparam logic [7:0]  IDL = 8'h00;
    localparam logic [7:0]  PAD = 8'hFF;

    typedef struct packed {
        logic [1:0] d;
        logic       sof;
        logic       eof;
        logic       idle;
    } beat_t;

    typedef struct packed {
        logic [2:0]  len;
        logic [31:0] words;
    } frame_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_data;
    logic       i_valid, i_last, i_ready;
    logic       o_ready, o_valid, o_sof, o_eof, o_idle;
    logic [1:0] o_data;

    int checks = 0;
    int passed = 0;

    beat_t      exp_q[$];
    frame_t     ready_q[$];
    logic [7:0] wbuf[$];
    logic       need_frame = 1'b1;
    logic       cur_is_data = 1'b0;
    logic       seen_valid = 1'b0;

    frame_packer #(
        .PAYLOAD_WORDS(PW),
        .IN_W         (8),
        .OUT_W        (2),
        .PREAMBLE_BITS(8),
        .PREAMBLE     (PRE),
        .IDLE_WORD    (IDL),
        .PAD_WORD     (PAD),
        .MSB_FIRST    (1'b1)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_data (i_data),
        .i_valid(i_valid),
        .i_last (i_last),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_sof  (o_sof),
        .o_eof  (o_eof),
        .o_idle (o_idle)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    // Expected beats of one frame, derived from the frame format directly.
    function automatic void push_frame(input logic is_idle, input frame_t f);
        beat_t      b;
        logic [7:0] wd;
        for (int k = 0; k < 4; k++) begin
            b.d    = 2'((PRE >> (6 - 2 * k)) & 8'h03);
            b.sof  = (k == 0);
            b.eof  = 1'b0;
            b.idle = is_idle;
            exp_q.push_back(b);
        end
        for (int w = 0; w < int'(PW); w++) begin
            if (is_idle) wd = IDL;
            else if (w < int'(f.len)) wd = f.words[w*8 +: 8];
            else wd = PAD;
            for (int k = 0; k < 4; k++) begin
                b.d    = 2'((wd >> (6 - 2 * k)) & 8'h03);
                b.sof  = 1'b0;
                b.eof  = (w == int'(PW) - 1) && (k == 3);
                b.idle = is_idle;
                exp_q.push_back(b);
            end
        end
    endfunction

    // Model step at each negedge: describes what the following posedge does.
    always @(negedge i_clk) begin
        frame_t f;
        beat_t  hd;
        logic   exp_ready, fire;
        if (i_reset) begin
            exp_q.delete();
            ready_q.delete();
            wbuf.delete();
            need_frame  = 1'b1;
            cur_is_data = 1'b0;
            seen_valid  = 1'b0;
        end else begin
            exp_ready = (ready_q.size() + (cur_is_data ? 1 : 0)) < 2;
            chk("o_ready", 32'(o_ready), 32'(exp_ready));
            chk("o_valid", 32'(o_valid), 32'(seen_valid));
            fire = o_valid && i_ready;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_underflow", 32'(o_valid), 32'd0);
                end else begin
                    hd = exp_q[0];
                    chk("beat", 32'({o_data, o_sof, o_eof, o_idle}), 32'(hd));
                    if (fire) begin
                        void'(exp_q.pop_front());
                        if (hd.eof) begin
                            cur_is_data = 1'b0;
                            need_frame  = 1'b1;
                        end
                    end
                end
            end
            if (need_frame) begin
                if (ready_q.size() > 0) begin
                    f = ready_q.pop_front();
                    cur_is_data = 1'b1;
                    push_frame(1'b0, f);
                end else begin
                    f = '0;
                    push_frame(1'b1, f);
                end
                need_frame = 1'b0;
                seen_valid = 1'b1;
            end
            if (i_valid && exp_ready) begin
                wbuf.push_back(i_data);
                if (i_last || wbuf.size() == PW) begin
                    f = '0;
                    f.len = 3'(wbuf.size());
                    for (int i = 0; i < wbuf.size(); i++) f.words[i*8 +: 8] = wbuf[i];
                    ready_q.push_back(f);
                    wbuf.delete();
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        logic acc;
        int   n;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 600) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: word %0h not accepted, required acceptance", d);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_data"},  32'(o_data),  32'd0);
        chk({tag, "_sof"},   32'(o_sof),   32'd0);
        chk({tag, "_eof"},   32'(o_eof),   32'd0);
        chk({tag, "_idle"},  32'(o_idle),  32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        #12;
        chk_reset_values("reset");
        @(posedge i_clk);
        #1 i_reset = 1'b0;

        // Idle frames, then one full data frame, then a short one.
        cycles(50);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        cycles(60);
        send(8'hC3, 1'b1);
        cycles(60);

        // Output stalled while 12 words arrive; the third frame waits for a free bank.
        i_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0);
            end
            begin
                cycles(40);
                i_ready = 1'b1;
            end
        join
        cycles(120);

        // Random lengths with random output backpressure.
        fork
            begin
                for (int i = 0; i < 24; i++) send(8'($urandom), ($urandom_range(0, 3) == 0));
            end
            begin
                repeat (400) begin
                    @(posedge i_clk);
                    #1 i_ready = 1'($urandom_range(0, 1));
                end
                i_ready = 1'b1;
            end
        join
        cycles(200);

        // Reset in the middle of a data frame's payload with another frame buffered.
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
        n = 0;
        while (n < 200 && !(o_valid && !o_idle)) begin
            cycles(1);
            n++;
        end
        chk("data_frame_started", 32'(o_valid && !o_idle), 32'd1);
        repeat (8) @(posedge i_clk);
        #3 i_reset = 1'b1;
        #1;
        chk_reset_values("midreset");
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        cycles(100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
